maple_tx_sequencer: RTL and testbench
=====================================

# maple_tx_sequencer

Transmit-side controller for one Maple Bus frame. It sequences three sub-blocks in a fixed order: the start-pattern encoder, the byte serializer, then the end-pattern encoder. It pulls payload bytes from an upstream byte source, appends the XOR checksum byte, and drives the bus-ownership select that the top-level SDCKA/SDCKB mux uses. A per-phase watchdog aborts the frame if a sub-block never reports done.

## Interface
- TIMEOUT, 255: max cycles to wait for any sub-block done pulse before abort (1..255).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- start  in  1  request to send one frame; sampled only in IDLE.
- len  in  8  payload byte count, latched with start; 0 is legal (checksum byte only).
- busy  out  1  high from the cycle after start is accepted until the cycle after FINISH/abort.
- done  out  1  one-cycle pulse: frame completed normally.
- error  out  1  one-cycle pulse: frame aborted by watchdog.
- byte_valid  in  1  upstream byte available.
- byte_data  in  8  upstream byte.
- byte_ready  out  1  high only in FETCH; transfer on edge with byte_valid&&byte_ready.
- pat_start_en  out  1  one-cycle enable pulse to start-pattern encoder.
- pat_start_done  in  1  done pulse from start-pattern encoder.
- ser_en  out  1  one-cycle enable pulse to byte serializer.
- ser_data  out  8  byte to serialize; stable from ser_en pulse until ser_done.
- ser_done  in  1  done pulse from serializer.
- pat_end_en  out  1  one-cycle enable pulse to end-pattern encoder.
- pat_end_done  in  1  done pulse from end-pattern encoder.
- bus_sel  out  2  line owner: 0 idle (lines high), 1 start pattern, 2 serializer, 3 end pattern.

## Operation
- States: IDLE, START_PAT, WAIT_START, FETCH, LOAD, WAIT_BYTE, END_PAT, WAIT_END, FINISH.
- IDLE: on start=1, latch remaining<=len, crc<=0, last<=0 -> START_PAT. start in any other state is ignored.
- START_PAT (1 cycle): pat_start_en=1, bus_sel=1 -> WAIT_START.
- WAIT_START: bus_sel=1. pat_start_done -> FETCH if remaining!=0. Otherwise tx_byte<=crc, last<=1 -> LOAD.
- FETCH: byte_ready=1, bus_sel=2, no watchdog. On transfer: tx_byte<=byte_data, crc<=crc^byte_data, remaining<=remaining-1 -> LOAD.
- LOAD (1 cycle): ser_en=1, bus_sel=2 -> WAIT_BYTE.
- WAIT_BYTE: on ser_done:
  - last=1 -> END_PAT.
  - else remaining!=0 -> FETCH.
  - else tx_byte<=crc, last<=1 -> LOAD.
- END_PAT (1 cycle): pat_end_en=1, bus_sel=3 -> WAIT_END.
- WAIT_END: bus_sel=3. pat_end_done -> FINISH.
- FINISH (1 cycle): done=1, bus_sel=0 -> IDLE.
- Watchdog: 8-bit counter cleared on entry to each WAIT_* state and incremented each cycle in it.
  - If the counter reaches TIMEOUT without the matching done pulse: error=1 for one cycle, go to IDLE, bus_sel=0.
  - A done pulse in the same cycle the counter reaches TIMEOUT wins; no error.
- Done pulses from sub-blocks not currently awaited are ignored.
- Arithmetic: remaining is 8-bit, never decremented below 0. crc is an 8-bit XOR of all payload bytes only.
- Reset values: state IDLE, busy=0, done=0, error=0, byte_ready=0, all *_en=0, ser_data=0x00, bus_sel=0, crc=0, remaining=0. Reset mid-frame aborts with no done/error pulse.

## Timing
- All outputs are registered or decoded from the registered state; no combinational path from inputs to outputs.
- start accepted at edge k: busy=1, bus_sel=1, and pat_start_en=1 during cycle k..k+1. pat_start_en drops after one cycle.
- Each *_en is exactly one cycle wide per phase. ser_data is valid in the ser_en cycle and held until the next LOAD.
- Done arriving at edge k advances state at edge k. The next enable pulse is asserted in the cycle after that edge (minimum one LOAD/*_PAT cycle).
- Byte transfer at edge k: ser_en is high in the following cycle.
- Watchdog abort: error asserted in the cycle after the counter reaches TIMEOUT. busy=0 in the cycle after that.
- Back-to-back frames: start may be accepted in the cycle after FINISH (IDLE).

## Test plan
- len=2, bytes 0xA5,0x3C, all dones after 5 cycles -> ser_data sequence A5,3C,99; bus_sel 1,2,3,0; one done pulse; byte_ready high for exactly 2 transfers.
- len=0 -> single serializer phase with ser_data=0x00, no byte_ready transfer, done pulse.
- byte_valid withheld 300 cycles in FETCH -> no error, frame completes after valid returns.
- TIMEOUT=8, pat_end_done never asserted -> error pulse 8 cycles after entering WAIT_END, bus_sel=0, no done; next start works.
- pat_start_done exactly at counter=TIMEOUT -> proceeds to FETCH, no error; start asserted while busy -> ignored.
- Async reset pulse mid WAIT_BYTE -> all outputs at reset values immediately; new frame afterwards sends correct checksum (crc not carried over).

Source files
------------

// File: rtl/maple_tx_sequencer.sv
// Maple Bus transmit sequencer: start pattern, payload bytes plus XOR checksum,
// end pattern, with a per-phase watchdog on every sub-block handshake.
module maple_tx_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] len_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_ready_o,
  output logic       pat_start_en_o,
  input  logic       pat_start_done_i,
  output logic       ser_en_o,
  output logic [7:0] ser_data_o,
  input  logic       ser_done_i,
  output logic       pat_end_en_o,
  input  logic       pat_end_done_i,
  output logic [1:0] bus_sel_o
);

  typedef enum logic [3:0] {
    IDLE, START_PAT, WAIT_START, FETCH, LOAD, WAIT_BYTE, END_PAT, WAIT_END, FINISH
  } state_t;

  localparam logic [1:0] SEL_IDLE = 2'd0;
  localparam logic [1:0] SEL_SPAT = 2'd1;
  localparam logic [1:0] SEL_SER  = 2'd2;
  localparam logic [1:0] SEL_EPAT = 2'd3;

  // Abort fires on the edge where the counter would step onto TIMEOUT, so a
  // done pulse sampled on that same edge still wins.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q;
  logic [7:0] rem_q, crc_q, tx_q, cnt_q;
  logic       last_q;
  logic       busy_q, done_q, error_q, byte_ready_q;
  logic       pat_start_en_q, ser_en_q, pat_end_en_q;
  logic [1:0] bus_sel_q;
  logic [7:0] crc_d;

  assign crc_d = crc_q ^ byte_data_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      rem_q          <= 8'd0;
      crc_q          <= 8'd0;
      tx_q           <= 8'd0;
      cnt_q          <= 8'd0;
      last_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      byte_ready_q   <= 1'b0;
      pat_start_en_q <= 1'b0;
      ser_en_q       <= 1'b0;
      pat_end_en_q   <= 1'b0;
      bus_sel_q      <= SEL_IDLE;
    end else begin
      pat_start_en_q <= 1'b0;
      ser_en_q       <= 1'b0;
      pat_end_en_q   <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q       <= 1'b0;
          bus_sel_q    <= SEL_IDLE;
          byte_ready_q <= 1'b0;
          if (start_i) begin
            rem_q          <= len_i;
            crc_q          <= 8'd0;
            last_q         <= 1'b0;
            busy_q         <= 1'b1;
            bus_sel_q      <= SEL_SPAT;
            pat_start_en_q <= 1'b1;
            state_q        <= START_PAT;
          end
        end
        START_PAT: begin
          cnt_q   <= 8'd0;
          state_q <= WAIT_START;
        end
        WAIT_START: begin
          if (pat_start_done_i) begin
            bus_sel_q <= SEL_SER;
            if (rem_q != 8'd0) begin
              byte_ready_q <= 1'b1;
              state_q      <= FETCH;
            end else begin
              tx_q     <= crc_q;
              last_q   <= 1'b1;
              ser_en_q <= 1'b1;
              state_q  <= LOAD;
            end
          end else if (cnt_q == TO_LAST) begin
            error_q   <= 1'b1;
            bus_sel_q <= SEL_IDLE;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        FETCH: begin
          // Upstream may stall indefinitely here; no watchdog.
          if (byte_valid_i) begin
            tx_q         <= byte_data_i;
            crc_q        <= crc_d;
            rem_q        <= (rem_q != 8'd0) ? rem_q - 8'd1 : 8'd0;
            byte_ready_q <= 1'b0;
            ser_en_q     <= 1'b1;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          cnt_q   <= 8'd0;
          state_q <= WAIT_BYTE;
        end
        WAIT_BYTE: begin
          if (ser_done_i) begin
            if (last_q) begin
              pat_end_en_q <= 1'b1;
              bus_sel_q    <= SEL_EPAT;
              state_q      <= END_PAT;
            end else if (rem_q != 8'd0) begin
              byte_ready_q <= 1'b1;
              state_q      <= FETCH;
            end else begin
              tx_q     <= crc_q;
              last_q   <= 1'b1;
              ser_en_q <= 1'b1;
              state_q  <= LOAD;
            end
          end else if (cnt_q == TO_LAST) begin
            error_q   <= 1'b1;
            bus_sel_q <= SEL_IDLE;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        END_PAT: begin
          cnt_q   <= 8'd0;
          state_q <= WAIT_END;
        end
        WAIT_END: begin
          if (pat_end_done_i) begin
            done_q    <= 1'b1;
            bus_sel_q <= SEL_IDLE;
            state_q   <= FINISH;
          end else if (cnt_q == TO_LAST) begin
            error_q   <= 1'b1;
            bus_sel_q <= SEL_IDLE;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          bus_sel_q <= SEL_IDLE;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign byte_ready_o   = byte_ready_q;
  assign pat_start_en_o = pat_start_en_q;
  assign ser_en_o       = ser_en_q;
  assign ser_data_o     = tx_q;
  assign pat_end_en_o   = pat_end_en_q;
  assign bus_sel_o      = bus_sel_q;

endmodule

// File: tb/tb_maple_tx_sequencer.sv
// Bench for maple_tx_sequencer: behavioural sub-block responders, a byte source
// and a scoreboard of expected serializer bytes checked on every ser_en pulse.
module tb_maple_tx_sequencer;
  localparam int TO = 8;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] len = 8'd0;
  logic       busy, done, error, byte_ready;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'd0;
  logic       pat_start_en, ser_en, pat_end_en;
  logic       pat_start_done = 1'b0, ser_done = 1'b0, pat_end_done = 1'b0;
  logic [7:0] ser_data;
  logic [1:0] bus_sel;

  maple_tx_sequencer #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .len_i(len),
    .busy_o(busy), .done_o(done), .error_o(error),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
    .pat_start_en_o(pat_start_en), .pat_start_done_i(pat_start_done),
    .ser_en_o(ser_en), .ser_data_o(ser_data), .ser_done_i(ser_done),
    .pat_end_en_o(pat_end_en), .pat_end_done_i(pat_end_done),
    .bus_sel_o(bus_sel)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];
  bit withhold = 1'b0;
  int d_start = 5, d_ser = 5, d_end = 5;
  int c_start = -1, c_ser = -1, c_end = -1;
  int ser_cnt, done_cnt, err_cnt, pse_cnt, xfer_cnt, sel_n;
  logic [31:0] sel_seq;
  logic [1:0]  prev_sel;

  // Sub-block responders: done pulses d_* negedges after the enable (-1 = never).
  always @(negedge clk) begin
    pat_start_done = 1'b0; ser_done = 1'b0; pat_end_done = 1'b0;
    if (reset) begin
      c_start = -1; c_ser = -1; c_end = -1;
    end else begin
      if (pat_start_en) c_start = d_start; else if (c_start > 0) c_start--;
      if (c_start == 0) begin pat_start_done = 1'b1; c_start = -1; end
      if (ser_en) c_ser = d_ser; else if (c_ser > 0) c_ser--;
      if (c_ser == 0) begin ser_done = 1'b1; c_ser = -1; end
      if (pat_end_en) c_end = d_end; else if (c_end > 0) c_end--;
      if (c_end == 0) begin pat_end_done = 1'b1; c_end = -1; end
    end
    byte_valid = !withhold && (src_q.size() != 0);
    byte_data  = (src_q.size() != 0) ? src_q[0] : 8'd0;
  end

  always @(posedge clk) begin
    if (!reset && byte_valid && byte_ready) begin
      void'(src_q.pop_front());
      xfer_cnt++;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset) begin
      if (ser_en) begin
        ser_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL ser_data_unexpected got=%02h expected=none", ser_data);
        end else begin
          e = exp_q.pop_front();
          if (ser_data !== e) begin
            failures++;
            $display("FAIL ser_data got=%02h expected=%02h", ser_data, e);
          end
        end
      end
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (pat_start_en) pse_cnt++;
      if (bus_sel !== prev_sel) begin
        sel_seq = {sel_seq[29:0], bus_sel};
        sel_n++;
        prev_sel = bus_sel;
      end
    end
  end

  task clr_stats();
    ser_cnt = 0; done_cnt = 0; err_cnt = 0; pse_cnt = 0; xfer_cnt = 0;
    sel_n = 0; sel_seq = 32'd0; prev_sel = bus_sel;
  endtask

  // Queue up to two payload bytes, push expected serializer stream, pulse start.
  // Returns at #1 after the accepting edge.
  task launch(input logic [7:0] n, input logic [7:0] b0, input logic [7:0] b1, input bit push_exp);
    logic [7:0] crc;
    crc = 8'd0;
    if (n > 0) begin src_q.push_back(b0); crc = crc ^ b0; if (push_exp) exp_q.push_back(b0); end
    if (n > 1) begin src_q.push_back(b1); crc = crc ^ b1; if (push_exp) exp_q.push_back(b1); end
    if (push_exp) exp_q.push_back(crc);
    @(posedge clk); #1;
    clr_stats();
    start = 1'b1; len = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task wait_end(input int lim);
    int k;
    k = 0;
    while (done_cnt + err_cnt == 0 && k < lim) begin @(posedge clk); k++; end
    if (done_cnt + err_cnt == 0) begin
      checks++; failures++;
      $display("FAIL wait_end no done/error within %0d cycles", lim);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task test_reset();
    #12;
    checks++;
    if ({busy, done, error, byte_ready, pat_start_en, ser_en, pat_end_en, bus_sel, ser_data} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%0h expected=0",
               {busy, done, error, byte_ready, pat_start_en, ser_en, pat_end_en, bus_sel, ser_data});
    end
    @(posedge clk); #1; reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({busy, bus_sel} !== 3'd0) begin
      failures++; $display("FAIL idle_after_reset got=%0h expected=0", {busy, bus_sel});
    end
  endtask

  task test_basic();
    d_start = 5; d_ser = 5; d_end = 5;
    launch(8'd2, 8'hA5, 8'h3C, 1'b1);
    checks++;
    if ({busy, bus_sel, pat_start_en} !== 4'b1_01_1) begin
      failures++; $display("FAIL start_accept got=%b expected=1011", {busy, bus_sel, pat_start_en});
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, bus_sel, pat_start_en} !== 4'b1_01_0) begin
      failures++; $display("FAIL start_en_width got=%b expected=1010", {busy, bus_sel, pat_start_en});
    end
    wait_end(300);
    checks++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      failures++; $display("FAIL basic_done got=%0d/%0d expected=1/0", done_cnt, err_cnt);
    end
    checks++;
    if (ser_cnt !== 3 || xfer_cnt !== 2) begin
      failures++; $display("FAIL basic_counts ser=%0d xfer=%0d expected=3/2", ser_cnt, xfer_cnt);
    end
    checks++;
    if (sel_n !== 4 || sel_seq[7:0] !== 8'h6C) begin
      failures++; $display("FAIL basic_bus_sel n=%0d seq=%02h expected=4/6c", sel_n, sel_seq[7:0]);
    end
    checks++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_end left=%0d busy=%b expected=0/0", exp_q.size(), busy);
    end
  endtask

  task test_len0();
    launch(8'd0, 8'h00, 8'h00, 1'b1);
    wait_end(300);
    checks++;
    if (ser_cnt !== 1 || xfer_cnt !== 0 || done_cnt !== 1) begin
      failures++; $display("FAIL len0 ser=%0d xfer=%0d done=%0d expected=1/0/1", ser_cnt, xfer_cnt, done_cnt);
    end
  endtask

  task test_fetch_stall();
    withhold = 1'b1;
    launch(8'd1, 8'h5A, 8'h00, 1'b1);
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (err_cnt !== 0 || byte_ready !== 1'b1 || bus_sel !== 2'd2) begin
      failures++; $display("FAIL stall_state err=%0d rdy=%b sel=%0d expected=0/1/2", err_cnt, byte_ready, bus_sel);
    end
    withhold = 1'b0;
    wait_end(300);
    checks++;
    if (done_cnt !== 1 || err_cnt !== 0 || ser_cnt !== 2) begin
      failures++; $display("FAIL stall_done done=%0d err=%0d ser=%0d expected=1/0/2", done_cnt, err_cnt, ser_cnt);
    end
  endtask

  task test_timeout_end();
    int k, n;
    d_end = -1;
    launch(8'd1, 8'h11, 8'h00, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!pat_end_en && k < 200);
    n = 0;
    do begin @(negedge clk); n++; end while (!error && n < 40);
    checks++;
    if (n !== TO + 1) begin
      failures++; $display("FAIL timeout_latency got=%0d expected=%0d", n, TO + 1);
    end
    checks++;
    if (bus_sel !== 2'd0 || done !== 1'b0) begin
      failures++; $display("FAIL timeout_outputs sel=%0d done=%b expected=0/0", bus_sel, done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err_cnt !== 1 || done_cnt !== 0) begin
      failures++; $display("FAIL timeout_after busy=%b err=%0d done=%0d expected=0/1/0", busy, err_cnt, done_cnt);
    end
    d_end = 5;
    launch(8'd1, 8'h22, 8'h00, 1'b1);
    wait_end(300);
    checks++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      failures++; $display("FAIL restart_after_abort done=%0d err=%0d expected=1/0", done_cnt, err_cnt);
    end
  endtask

  task test_exact_timeout();
    int k;
    d_start = TO;
    launch(8'd1, 8'hC3, 8'h00, 1'b1);
    k = 0;
    while (!byte_ready && k < 100) begin @(posedge clk); #1; k++; end
    start = 1'b1; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_end(300);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (err_cnt !== 0 || done_cnt !== 1 || xfer_cnt !== 1 || ser_cnt !== 2) begin
      failures++; $display("FAIL exact_timeout err=%0d done=%0d xfer=%0d ser=%0d expected=0/1/1/2",
                           err_cnt, done_cnt, xfer_cnt, ser_cnt);
    end
    checks++;
    if (pse_cnt !== 1 || busy !== 1'b0) begin
      failures++; $display("FAIL start_while_busy pse=%0d busy=%b expected=1/0", pse_cnt, busy);
    end
    d_start = TO + 1;
    launch(8'd1, 8'h77, 8'h00, 1'b0);
    wait_end(300);
    checks++;
    if (err_cnt !== 1 || done_cnt !== 0 || ser_cnt !== 0) begin
      failures++; $display("FAIL late_start_done err=%0d done=%0d ser=%0d expected=1/0/0", err_cnt, done_cnt, ser_cnt);
    end
    src_q.delete();
    d_start = 5;
  endtask

  task test_async_reset();
    int k;
    d_ser = 5;
    launch(8'd2, 8'h12, 8'h34, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!ser_en && k < 100);
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, error, byte_ready, pat_start_en, ser_en, pat_end_en, bus_sel, ser_data} !== 15'd0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%0h expected=0",
               {busy, done, error, byte_ready, pat_start_en, ser_en, pat_end_en, bus_sel, ser_data});
    end
    @(negedge clk); @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    src_q.delete();
    checks++;
    if (done_cnt !== 0 || err_cnt !== 0) begin
      failures++; $display("FAIL async_reset_pulses done=%0d err=%0d expected=0/0", done_cnt, err_cnt);
    end
    launch(8'd1, 8'h0F, 8'h00, 1'b1);
    wait_end(300);
    checks++;
    if (done_cnt !== 1 || ser_cnt !== 2) begin
      failures++; $display("FAIL post_reset_frame done=%0d ser=%0d expected=1/2", done_cnt, ser_cnt);
    end
  endtask

  initial begin
    clr_stats();
    test_reset();
    test_basic();
    test_len0();
    test_fetch_stall();
    test_timeout_end();
    test_exact_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
